// File: rtl/vanilla_sb_latency_monitor.sv
// Measures per-register scoreboard latency (issue to clear) for int and float files and queues records.
// Define VANILLA_SB_LATENCY_MONITOR_ASSERT_EN to report protocol violations with $error.
module vanilla_sb_latency_monitor #(
    parameter int reg_els_p       = 32,
    parameter int latency_width_p = 16,
    parameter int fifo_els_p      = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       int_issue_v_i,
    input  logic [4:0]                 int_issue_id_i,
    input  logic                       float_issue_v_i,
    input  logic [4:0]                 float_issue_id_i,
    input  logic                       int_sb_clear_i,
    input  logic [4:0]                 int_sb_clear_id_i,
    input  logic                       float_sb_clear_i,
    input  logic [4:0]                 float_sb_clear_id_i,
    output logic                       rec_v_o,
    input  logic                       rec_ready_i,
    output logic                       rec_is_float_o,
    output logic [4:0]                 rec_id_o,
    output logic [latency_width_p-1:0] rec_latency_o,
    output logic [latency_width_p-1:0] drop_count_o,
    output logic [latency_width_p-1:0] err_count_o
);

    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int rec_w_lp = 1 + 5 + latency_width_p;
    localparam logic [ptr_w_lp:0] depth_lp = fifo_els_p[ptr_w_lp:0];

    typedef logic [latency_width_p-1:0] lat_t;

    function automatic lat_t sat_add(input lat_t a, input logic [2:0] inc);
        logic [latency_width_p:0] sum;
        sum = {1'b0, a} + {{(latency_width_p-2){1'b0}}, inc};
        return sum[latency_width_p] ? '1 : sum[latency_width_p-1:0];
    endfunction

    logic [reg_els_p-1:0] int_out_q, float_out_q;
    lat_t                 int_cnt_q   [reg_els_p];
    lat_t                 float_cnt_q [reg_els_p];
    logic [rec_w_lp-1:0]  mem_q       [fifo_els_p];
    logic [ptr_w_lp:0]    wptr_q, rptr_q, used, free;
    lat_t                 drop_count_q, err_count_q;

    logic int_clr_hit, int_clr_err, int_iss_err;
    logic float_clr_hit, float_clr_err, float_iss_err;
    logic pop, int_push, float_push;
    logic [1:0] push_n;
    logic [2:0] drop_inc, err_inc;
    logic [ptr_w_lp-1:0] wr_idx_int, wr_idx_float;
    logic [rec_w_lp-1:0] int_rec, float_rec;

    assign int_clr_hit   = int_sb_clear_i & int_out_q[int_sb_clear_id_i];
    assign int_clr_err   = int_sb_clear_i & ~int_out_q[int_sb_clear_id_i];
    assign int_iss_err   = int_issue_v_i & int_out_q[int_issue_id_i]
                         & ~(int_sb_clear_i && (int_sb_clear_id_i == int_issue_id_i));
    assign float_clr_hit = float_sb_clear_i & float_out_q[float_sb_clear_id_i];
    assign float_clr_err = float_sb_clear_i & ~float_out_q[float_sb_clear_id_i];
    assign float_iss_err = float_issue_v_i & float_out_q[float_issue_id_i]
                         & ~(float_sb_clear_i && (float_sb_clear_id_i == float_issue_id_i));

    // A pop this cycle frees a slot for this cycle's pushes; int claims space before float.
    assign rec_v_o    = (wptr_q != rptr_q);
    assign pop        = rec_v_o & rec_ready_i;
    assign used       = wptr_q - rptr_q;
    assign free       = depth_lp - used + {{ptr_w_lp{1'b0}}, pop};
    assign int_push   = int_clr_hit & (free != '0);
    assign float_push = float_clr_hit & (free > {{ptr_w_lp{1'b0}}, int_push});
    assign push_n     = {1'b0, int_push} + {1'b0, float_push};

    assign drop_inc = {2'b0, int_clr_hit & ~int_push} + {2'b0, float_clr_hit & ~float_push};
    assign err_inc  = {2'b0, int_clr_err} + {2'b0, int_iss_err}
                    + {2'b0, float_clr_err} + {2'b0, float_iss_err};

    assign int_rec      = {1'b0, int_sb_clear_id_i, int_cnt_q[int_sb_clear_id_i]};
    assign float_rec    = {1'b1, float_sb_clear_id_i, float_cnt_q[float_sb_clear_id_i]};
    assign wr_idx_int   = wptr_q[ptr_w_lp-1:0];
    assign wr_idx_float = wptr_q[ptr_w_lp-1:0] + {{(ptr_w_lp-1){1'b0}}, int_push};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            int_out_q    <= '0;
            float_out_q  <= '0;
            for (int r = 0; r < reg_els_p; r++) begin
                int_cnt_q[r]   <= '0;
                float_cnt_q[r] <= '0;
            end
            wptr_q       <= '0;
            rptr_q       <= '0;
            drop_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            // Issue restarts tracking even when the same register is being cleared.
            for (int r = 0; r < reg_els_p; r++) begin
                if (int_issue_v_i && (int_issue_id_i == 5'(r))) begin
                    int_out_q[r] <= 1'b1;
                    int_cnt_q[r] <= lat_t'(1);
                end else if (int_clr_hit && (int_sb_clear_id_i == 5'(r))) begin
                    int_out_q[r] <= 1'b0;
                end else if (int_out_q[r]) begin
                    int_cnt_q[r] <= sat_add(int_cnt_q[r], 3'd1);
                end
                if (float_issue_v_i && (float_issue_id_i == 5'(r))) begin
                    float_out_q[r] <= 1'b1;
                    float_cnt_q[r] <= lat_t'(1);
                end else if (float_clr_hit && (float_sb_clear_id_i == 5'(r))) begin
                    float_out_q[r] <= 1'b0;
                end else if (float_out_q[r]) begin
                    float_cnt_q[r] <= sat_add(float_cnt_q[r], 3'd1);
                end
            end
            wptr_q       <= wptr_q + (ptr_w_lp+1)'(push_n);
            rptr_q       <= rptr_q + (ptr_w_lp+1)'(pop);
            drop_count_q <= sat_add(drop_count_q, drop_inc);
            err_count_q  <= sat_add(err_count_q, err_inc);
        end
    end

    // Record storage carries no reset; pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (int_push)   mem_q[wr_idx_int]   <= int_rec;
        if (float_push) mem_q[wr_idx_float] <= float_rec;
    end

    assign {rec_is_float_o, rec_id_o, rec_latency_o} = mem_q[rptr_q[ptr_w_lp-1:0]];
    assign drop_count_o = drop_count_q;
    assign err_count_o  = err_count_q;

`ifdef VANILLA_SB_LATENCY_MONITOR_ASSERT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (int_clr_err)
                $error("%0t %s: int clear of non-outstanding register %0d", $time, `__FILE__, int_sb_clear_id_i);
            if (int_iss_err)
                $error("%0t %s: int issue to outstanding register %0d", $time, `__FILE__, int_issue_id_i);
            if (float_clr_err)
                $error("%0t %s: float clear of non-outstanding register %0d", $time, `__FILE__, float_sb_clear_id_i);
            if (float_iss_err)
                $error("%0t %s: float issue to outstanding register %0d", $time, `__FILE__, float_issue_id_i);
        end
    end
`else
    // Violations are only counted in err_count_o.
`endif

endmodule

// File: tb/tb_vanilla_sb_latency_monitor.sv
// Scoreboard bench for vanilla_sb_latency_monitor: directed issue/clear sequences, monitor checks records.
module tb_vanilla_sb_latency_monitor;

    typedef logic [21:0] rec_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        int_issue_v_i, float_issue_v_i, int_sb_clear_i, float_sb_clear_i;
    logic [4:0]  int_issue_id_i, float_issue_id_i, int_sb_clear_id_i, float_sb_clear_id_i;
    logic        rec_v_o, rec_ready_i, rec_is_float_o;
    logic [4:0]  rec_id_o;
    logic [15:0] rec_latency_o, drop_count_o, err_count_o;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    vanilla_sb_latency_monitor dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .int_issue_v_i      (int_issue_v_i),
        .int_issue_id_i     (int_issue_id_i),
        .float_issue_v_i    (float_issue_v_i),
        .float_issue_id_i   (float_issue_id_i),
        .int_sb_clear_i     (int_sb_clear_i),
        .int_sb_clear_id_i  (int_sb_clear_id_i),
        .float_sb_clear_i   (float_sb_clear_i),
        .float_sb_clear_id_i(float_sb_clear_id_i),
        .rec_v_o            (rec_v_o),
        .rec_ready_i        (rec_ready_i),
        .rec_is_float_o     (rec_is_float_o),
        .rec_id_o           (rec_id_o),
        .rec_latency_o      (rec_latency_o),
        .drop_count_o       (drop_count_o),
        .err_count_o        (err_count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        int_issue_v_i    = 1'b0;
        float_issue_v_i  = 1'b0;
        int_sb_clear_i   = 1'b0;
        float_sb_clear_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input logic f, input logic [4:0] id, input logic [15:0] lat);
        exp_q.push_back({f, id, lat});
    endtask

    task automatic int_issue(input logic [4:0] id);
        int_issue_v_i = 1'b1; int_issue_id_i = id;
    endtask
    task automatic int_clear(input logic [4:0] id);
        int_sb_clear_i = 1'b1; int_sb_clear_id_i = id;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_fifo_empty"}, rec_v_o, 0);
    endtask

    // Monitor: every accepted record must match the oldest expected one.
    initial begin
        rec_t got, want;
        forever begin
            @(negedge clk_i);
            if (!reset_i && rec_v_o && rec_ready_i) begin
                got = {rec_is_float_o, rec_id_o, rec_latency_o};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_record: got f=%0d id=%0d lat=%0d required none",
                             got[21], got[20:16], got[15:0]);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL record: got f=%0d id=%0d lat=%0d required f=%0d id=%0d lat=%0d",
                                 got[21], got[20:16], got[15:0], want[21], want[20:16], want[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        reset_i = 1'b1; rec_ready_i = 1'b1;
        int_issue_id_i = '0; float_issue_id_i = '0; int_sb_clear_id_i = '0; float_sb_clear_id_i = '0;
        tick();
        tick();
        chk("reset_rec_v", rec_v_o, 0);
        chk("reset_err", err_count_o, 0);
        chk("reset_drop", drop_count_o, 0);
        reset_i = 1'b0;

        // Issue r5, clear four cycles later: latency 4, visible the cycle after the clear
        int_issue(5); tick(); idle(3);
        chk("lat4_not_yet_valid", rec_v_o, 0);
        int_clear(5); push_exp(0, 5, 4); tick();
        chk("lat4_valid_next_cycle", rec_v_o, 1);
        wait_drain("lat4");

        // Float clear with nothing outstanding
        float_sb_clear_i = 1'b1; float_sb_clear_id_i = 3; tick();
        chk("float_bad_clear_err", err_count_o, 1);
        chk("float_bad_clear_no_rec", rec_v_o, 0);

        // Same-cycle issue and clear: old record pushed, tracking restarts at 1
        int_issue(2); tick(); tick();
        int_issue(2); int_clear(2); push_exp(0, 2, 2); tick();
        int_clear(2); push_exp(0, 2, 1); tick();
        chk("reissue_with_clear_no_err", err_count_o, 1);
        wait_drain("reissue");

        // Issue to an outstanding register: error, counter restarts
        int_issue(4); tick(); tick();
        int_issue(4); tick();
        chk("double_issue_err", err_count_o, 2);
        int_clear(4); push_exp(0, 4, 1); tick();
        wait_drain("double_issue");

        // Simultaneous int and float clears: int record first
        int_issue(10); float_issue_v_i = 1'b1; float_issue_id_i = 11; tick(); tick();
        int_clear(10); float_sb_clear_i = 1'b1; float_sb_clear_id_i = 11;
        push_exp(0, 10, 2); push_exp(1, 11, 2); tick();
        wait_drain("simul");

        // Consumer stalled, five clears into a depth-4 FIFO
        rec_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin int_issue(5'(k)); tick(); end
        for (int k = 0; k < 5; k++) begin
            int_clear(5'(k));
            if (k < 4) push_exp(0, 5'(k), 5);
            tick();
        end
        chk("overflow_drop", drop_count_o, 1);
        chk("overflow_held_valid", rec_v_o, 1);
        chk("overflow_held_id", rec_id_o, 0);
        rec_ready_i = 1'b1;
        wait_drain("overflow");

        // FIFO at 3/4, int and float clear together: float dropped
        rec_ready_i = 1'b0;
        for (int k = 20; k < 23; k++) begin int_issue(5'(k)); tick(); end
        for (int k = 20; k < 23; k++) begin int_clear(5'(k)); push_exp(0, 5'(k), 3); tick(); end
        int_issue(1); float_issue_v_i = 1'b1; float_issue_id_i = 2; tick();
        int_clear(1); float_sb_clear_i = 1'b1; float_sb_clear_id_i = 2; push_exp(0, 1, 1); tick();
        chk("three_quarter_drop", drop_count_o, 2);
        // Full FIFO: a same-cycle pop makes room for the push
        int_issue(30); tick();
        rec_ready_i = 1'b1; int_clear(30); push_exp(0, 30, 1); tick();
        chk("pop_frees_slot_no_drop", drop_count_o, 2);
        wait_drain("three_quarter");
        chk("err_before_sat", err_count_o, 2);

        // Latency saturation
        int_issue(7); tick(); idle(69999);
        int_clear(7); push_exp(0, 7, 16'hFFFF); tick();
        wait_drain("saturate");

        // Reset mid-flight discards tracking; inputs during reset ignored
        int_issue(9); tick(); idle(2);
        reset_i = 1'b1; int_issue(12); tick(); tick();
        chk("midreset_rec_v", rec_v_o, 0);
        reset_i = 1'b0;
        chk("midreset_err_cleared", err_count_o, 0);
        chk("midreset_drop_cleared", drop_count_o, 0);
        int_clear(9); tick();
        chk("after_reset_clear_err", err_count_o, 1);
        chk("after_reset_no_rec", rec_v_o, 0);
        int_clear(12); tick();
        chk("issue_in_reset_ignored", err_count_o, 2);
        idle(2);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vanilla_sb_latency_monitor.md
VANILLA_SB_LATENCY_MONITOR -- requirements
Module: vanilla_sb_latency_monitor

Interface
REQ-001 Parameters SHALL be: reg_els_p, 32, registers per file; latency_width_p, 16, latency/counter width; fifo_els_p, 4, record FIFO depth (power of 2, >=2).
REQ-002 Ports SHALL be (name direction width meaning):
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous active-high reset.
- int_issue_v_i  in  1  int remote load/amo/idiv issued to int_issue_id_i.
- int_issue_id_i  in  5  int destination register.
- float_issue_v_i  in  1  float remote load/fdiv/fsqrt issued to float_issue_id_i.
- float_issue_id_i  in  5  float destination register.
- int_sb_clear_i  in  1  int scoreboard clear.
- int_sb_clear_id_i  in  5  int register cleared.
- float_sb_clear_i  in  1  float scoreboard clear.
- float_sb_clear_id_i  in  5  float register cleared.
- rec_v_o  out  1  latency record valid.
- rec_ready_i  in  1  consumer accepts record.
- rec_is_float_o  out  1  record is for float file.
- rec_id_o  out  5  record register id.
- rec_latency_o  out  latency_width_p  measured latency.
- drop_count_o  out  latency_width_p  records dropped on FIFO full.
- err_count_o  out  latency_width_p  protocol violations.

Function
REQ-003 Per register per file SHALL hold an outstanding bit and a latency counter.
REQ-004 Issue to register r SHALL set outstanding[r] and load counter[r]=1 at next edge.
REQ-005 While outstanding and not cleared, counter SHALL increment each cycle, saturating at 2^latency_width_p-1.
REQ-006 Clear of outstanding r SHALL clear outstanding[r] and push {is_float, r, counter[r]} to the FIFO in that cycle; issue cycle T, clear cycle T+1 -> latency 1.
REQ-007 Clear of non-outstanding r SHALL push nothing and increment err_count_o.
REQ-008 Issue to already-outstanding r (without same-cycle clear of r) SHALL increment err_count_o and restart counter[r]=1.
REQ-009 Issue and clear of same r same cycle SHALL push the old record and restart tracking with counter 1.
REQ-010 Simultaneous int and float pushes SHALL enqueue int first, then float.
REQ-011 FIFO pop SHALL occur on rec_v_o & rec_ready_i; a same-cycle pop frees a slot for that cycle's pushes.
REQ-012 Pushes exceeding free slots SHALL be dropped (float dropped first), each incrementing drop_count_o.
REQ-013 Both error events in one cycle SHALL add their total count; all counters saturate.
REQ-014 rec_v_o SHALL assert the cycle after a push into empty FIFO (no bypass); outputs SHALL hold stable while rec_v_o & ~rec_ready_i.
REQ-015 Issue/clear ids SHALL be ignored when their valid is low.

Reset
REQ-016 reset_i SHALL clear all outstanding bits, counters, FIFO pointers, drop_count_o, err_count_o; rec_v_o=0 in the cycle after reset asserts.
REQ-017 Reset mid-operation SHALL discard outstanding entries and queued records without counting them.
REQ-018 Inputs SHALL be ignored while reset_i is high.

Configuration
REQ-019 Macro VANILLA_SB_LATENCY_MONITOR_ASSERT_EN defined: each REQ-007/REQ-008 violation SHALL raise $error with time, file, register id; undefined: counting only, no messages.

Verification
REQ-020 Int issue r5 cycle 10, clear r5 cycle 14 -> one record {0,5,4}, rec_v_o cycle 15.
REQ-021 Float clear r3 with nothing outstanding -> no record, err_count_o=1; with macro, exactly one $error.
REQ-022 rec_ready_i=0, 5 sequential int clears with depth 4 -> 4 records held in order, drop_count_o=1.
REQ-023 FIFO 3/4 full, int r1 and float r2 clear same cycle, rec_ready_i=0 -> int record queued, float dropped, drop_count_o=1.
REQ-024 Issue r7 held 70000 cycles before clear (latency_width_p=16) -> rec_latency_o=65535.
REQ-025 Issue r9, reset mid-flight, then clear r9 -> no record, err_count_o=1.
